// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment capture block:
//   - active-low segment patterns for the digits 0..9 and the blank display
//   - segment bit positions (bit0 = a ... bit6 = g)
//   - the decode result record produced by seg7_pattern_decode
// ---------------------------------------------------------------------------
package seg7_pkg;

    // Segment bit positions inside seg_n
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-low patterns, written bit6..bit0 (g..a); a 0 lights the segment
    localparam logic [6:0] SEG7_0     = 7'h40;
    localparam logic [6:0] SEG7_1     = 7'h79;
    localparam logic [6:0] SEG7_2     = 7'h24;
    localparam logic [6:0] SEG7_3     = 7'h30;
    localparam logic [6:0] SEG7_4     = 7'h19;
    localparam logic [6:0] SEG7_5     = 7'h12;
    localparam logic [6:0] SEG7_6     = 7'h02;
    localparam logic [6:0] SEG7_7     = 7'h58;
    localparam logic [6:0] SEG7_8     = 7'h00;
    localparam logic [6:0] SEG7_9     = 7'h10;
    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    // legal : pattern is one of the eleven recognised ones (digit or blank)
    // blank : pattern is the all-off blank
    // value : BCD value of a digit pattern, 0 for blank or illegal
    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] value;
    } seg7_dec_t;

endpackage

// File: rtl/seg7_capture_if.sv
// ---------------------------------------------------------------------------
// seg7_capture_if
// The multiplexed display bus being snooped.
//   seg_n    : active-low segments, bit0 = a ... bit6 = g
//   dig_en_n : active-low digit enables, one-hot-low when legal
// Modports:
//   master : whoever drives the display (display path or testbench)
//   slave  : the capture block, which only observes the bus
// ---------------------------------------------------------------------------
interface seg7_capture_if #(
    parameter int DIGITS = 4
);
    logic [6:0]        seg_n;
    logic [DIGITS-1:0] dig_en_n;

    modport master (output seg_n, output dig_en_n);
    modport slave  (input  seg_n, input  dig_en_n);
endinterface

// File: rtl/seg7_pattern_decode.sv
// ---------------------------------------------------------------------------
// seg7_pattern_decode
// Purely combinational: maps an active-low segment pattern onto a decode
// record (legal / blank / BCD value).
// Ports:
//   seg_n_i : active-low segment pattern
//   dec_o   : decode result
// ---------------------------------------------------------------------------
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n_i,
    output seg7_dec_t  dec_o
);

    // Anything outside the eleven known patterns stays at the illegal default
    always_comb begin
        dec_o = '0;
        unique case (seg_n_i)
            SEG7_0:     begin dec_o.legal = 1'b1; dec_o.value = 4'd0; end
            SEG7_1:     begin dec_o.legal = 1'b1; dec_o.value = 4'd1; end
            SEG7_2:     begin dec_o.legal = 1'b1; dec_o.value = 4'd2; end
            SEG7_3:     begin dec_o.legal = 1'b1; dec_o.value = 4'd3; end
            SEG7_4:     begin dec_o.legal = 1'b1; dec_o.value = 4'd4; end
            SEG7_5:     begin dec_o.legal = 1'b1; dec_o.value = 4'd5; end
            SEG7_6:     begin dec_o.legal = 1'b1; dec_o.value = 4'd6; end
            SEG7_7:     begin dec_o.legal = 1'b1; dec_o.value = 4'd7; end
            SEG7_8:     begin dec_o.legal = 1'b1; dec_o.value = 4'd8; end
            SEG7_9:     begin dec_o.legal = 1'b1; dec_o.value = 4'd9; end
            SEG7_BLANK: begin dec_o.legal = 1'b1; dec_o.blank = 1'b1; end
            default:    dec_o = '0;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// ---------------------------------------------------------------------------
// seg7_capture
// Snoops a time-multiplexed active-low 7-segment bus and recovers the BCD
// digit shown in each position. A position/pattern pair must be seen for
// STABLE_CYCLES consecutive clocks before it is accepted, which filters the
// ghosting around scan transitions.
//
// Optional feature macro: SEG7_CAP_SYNC_EN
//   defined   : seg_n and dig_en_n go through a two-flop synchronizer
//               (reset to all-ones) before sampling, adding 2 clk latency
//   undefined : bus is sampled directly and must be synchronous to clk
//
// Ports:
//   clk           : system clock
//   rst_n         : asynchronous active-low reset
//   bus           : display bus (slave modport)
//   clear_i       : synchronous clear of digit_valid, blank and frame tracking
//   digits_o      : recovered BCD, nibble i = position i
//   digit_valid_o : position i accepted since reset or clear
//   blank_o       : position i last accepted as blank
//   frame_valid_o : one-cycle pulse once every position has been accepted
//   err_o         : one-cycle pulse on an illegal stable pattern
// ---------------------------------------------------------------------------
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_capture_if.slave         bus,
    input  logic                  clear_i,
    output logic [4*DIGITS-1:0]   digits_o,
    output logic [DIGITS-1:0]     digit_valid_o,
    output logic [DIGITS-1:0]     blank_o,
    output logic                  frame_valid_o,
    output logic                  err_o
);

    localparam int               POS_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);

    logic [6:0]        sampSeg;
    logic [DIGITS-1:0] sampDigEn;

`ifdef SEG7_CAP_SYNC_EN
    logic [6:0]        segSync1_q, segSync2_q;
    logic [DIGITS-1:0] enSync1_q,  enSync2_q;

    // Two-flop synchronizer; all-ones reset reads as "no digit enabled, blank"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segSync1_q <= '1;
            segSync2_q <= '1;
            enSync1_q  <= '1;
            enSync2_q  <= '1;
        end else begin
            segSync1_q <= bus.seg_n;
            segSync2_q <= segSync1_q;
            enSync1_q  <= bus.dig_en_n;
            enSync2_q  <= enSync1_q;
        end
    end

    assign sampSeg   = segSync2_q;
    assign sampDigEn = enSync2_q;
`else
    assign sampSeg   = bus.seg_n;
    assign sampDigEn = bus.dig_en_n;
`endif

    seg7_dec_t dec;

    seg7_pattern_decode u_decode (
        .seg_n_i (sampSeg),
        .dec_o   (dec)
    );

    logic [DIGITS-1:0] posOh;
    logic [POS_W-1:0]  posIdx;
    logic              posLegal;

    // A position is legal only when exactly one enable is low
    always_comb begin
        posOh    = ~sampDigEn;
        posIdx   = '0;
        posLegal = (posOh != '0) && ((posOh & (posOh - DIGITS'(1))) == '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (posOh[i]) begin
                posIdx = i[POS_W-1:0];
            end
        end
    end

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [6:0]        prevSeg_q;
    logic [POS_W-1:0]  prevPos_q;
    logic              prevValid_q;
    logic              sameAsPrev;
    logic              accept;

    // prevValid_q low means "no previous position", so returning to the same
    // digit after a scan gap always restarts the count from 1.
    // accept fires only on the transition into STABLE_CYCLES, so a long dwell
    // acts exactly once while the counter sits saturated.
    always_comb begin
        sameAsPrev = prevValid_q && (posIdx == prevPos_q) && (sampSeg == prevSeg_q);
        cnt_d      = '0;
        if (!posLegal) begin
            cnt_d = '0;
        end else if (sameAsPrev) begin
            cnt_d = (cnt_q == STABLE_C) ? STABLE_C : cnt_q + CNT_W'(1);
        end else begin
            cnt_d = CNT_W'(1);
        end
        accept = posLegal && (cnt_q != STABLE_C) && (cnt_d == STABLE_C);
    end

    // Stability counter and previous-sample history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            prevSeg_q   <= 7'h7F;
            prevPos_q   <= '0;
            prevValid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            prevSeg_q   <= sampSeg;
            prevPos_q   <= posIdx;
            prevValid_q <= posLegal;
        end
    end

    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic [DIGITS-1:0]   valid_q, valid_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic [DIGITS-1:0]   acceptMask;
    logic [DIGITS-1:0]   seenNext;
    logic                frame_d, frame_q;
    logic                err_d, err_q;

    // Result update. clear wins over a same-cycle acceptance, which is then
    // dropped entirely (digits keep their old value). When the seen mask
    // fills, frame_valid pulses and the mask restarts empty on the same edge.
    always_comb begin
        digits_d   = digits_q;
        valid_d    = valid_q;
        blank_d    = blank_q;
        seen_d     = seen_q;
        frame_d    = 1'b0;
        acceptMask = '0;
        seenNext   = seen_q;
        err_d      = accept && !dec.legal;

        acceptMask[posIdx] = accept && dec.legal;

        if (clear_i) begin
            valid_d = '0;
            blank_d = '0;
            seen_d  = '0;
        end else if (acceptMask != '0) begin
            digits_d[int'(posIdx)*4 +: 4] = dec.blank ? 4'd0 : dec.value;
            valid_d  = valid_q | acceptMask;
            blank_d  = dec.blank ? (blank_q | acceptMask) : (blank_q & ~acceptMask);
            seenNext = seen_q | acceptMask;
            if (&seenNext) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d  = seenNext;
            end
        end
    end

    // Result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
            valid_q  <= '0;
            blank_q  <= '0;
            seen_q   <= '0;
            frame_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            digits_q <= digits_d;
            valid_q  <= valid_d;
            blank_q  <= blank_d;
            seen_q   <= seen_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
        end
    end

    assign digits_o      = digits_q;
    assign digit_valid_o = valid_q;
    assign blank_o       = blank_q;
    assign frame_valid_o = frame_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// ---------------------------------------------------------------------------
// tb_seg7_capture
// Directed bench for seg7_capture with DIGITS=4, STABLE_CYCLES=8. A table of
// dwell vectors (position, pattern, hold length, expected outputs) is applied
// with an idle gap between entries so each dwell restarts counting, followed
// by hand-written sequences for toggling, mid-dwell reset and clear.
// ---------------------------------------------------------------------------
module tb_seg7_capture;

    localparam int DIGITS = 4;
    localparam int NVEC   = 13;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [15:0] digits;
    logic [3:0]  digitValid;
    logic [3:0]  blank;
    logic        frameValid;
    logic        err;

    int checks   = 0;
    int failures = 0;

    seg7_capture_if #(.DIGITS(DIGITS)) bus ();

    seg7_capture #(
        .DIGITS        (DIGITS),
        .STABLE_CYCLES (8),
        .CNT_W         (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .clear_i       (clear),
        .digits_o      (digits),
        .digit_valid_o (digitValid),
        .blank_o       (blank),
        .frame_valid_o (frameValid),
        .err_o         (err)
    );

    // Free-running 100 MHz-style clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  digEn;
        logic [6:0]  seg;
        int          hold;
        logic [15:0] expDigits;
        logic [3:0]  expValid;
        logic [3:0]  expBlank;
        int          expErr;
        int          expFrame;
    } vec_t;

    vec_t vecs [NVEC];

    // One comparison; failures is the count reported in the summary
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one pattern for n clocks, counting err/frame pulses seen after each edge
    task automatic applyStimulus(input logic [3:0] en, input logic [6:0] seg,
                                 input int n, output int errs, output int frames);
        errs   = 0;
        frames = 0;
        bus.dig_en_n = en;
        bus.seg_n    = seg;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            errs   += int'(err);
            frames += int'(frameValid);
        end
    endtask

    // One idle clock (no enables) so the next dwell starts counting afresh
    task automatic applyGap(input string name);
        bus.dig_en_n = 4'hF;
        bus.seg_n    = 7'h7F;
        @(posedge clk);
        #1;
        checkOutput({name, " gap frame"}, 32'(frameValid), 32'd0);
        checkOutput({name, " gap err"},   32'(err),        32'd0);
    endtask

    initial begin
        int e;
        int f;
        int et;
        int ft;

        vecs[0]  = '{"pos0 2",        4'hE, 7'h24,  8, 16'h0002, 4'h1, 4'h0, 0, 0};
        vecs[1]  = '{"pos0 3",        4'hE, 7'h30, 10, 16'h0003, 4'h1, 4'h0, 0, 0};
        vecs[2]  = '{"pos1 4",        4'hD, 7'h19, 10, 16'h0043, 4'h3, 4'h0, 0, 0};
        vecs[3]  = '{"pos2 5",        4'hB, 7'h12, 10, 16'h0543, 4'h7, 4'h0, 0, 0};
        vecs[4]  = '{"pos3 7 frame",  4'h7, 7'h58, 10, 16'h7543, 4'hF, 4'h0, 0, 1};
        vecs[5]  = '{"pos1 blank",    4'hD, 7'h7F,  8, 16'h7503, 4'hF, 4'h2, 0, 0};
        vecs[6]  = '{"pos2 illegal",  4'hB, 7'h7E, 20, 16'h7503, 4'hF, 4'h2, 1, 0};
        vecs[7]  = '{"two enables",   4'hC, 7'h40, 20, 16'h7503, 4'hF, 4'h2, 0, 0};
        vecs[8]  = '{"pos0 short",    4'hE, 7'h40,  7, 16'h7503, 4'hF, 4'h2, 0, 0};
        vecs[9]  = '{"pos0 0",        4'hE, 7'h40,  8, 16'h7500, 4'hF, 4'h2, 0, 0};
        vecs[10] = '{"pos3 6",        4'h7, 7'h02,  8, 16'h6500, 4'hF, 4'h2, 0, 0};
        vecs[11] = '{"pos2 8 frame",  4'hB, 7'h00,  8, 16'h6800, 4'hF, 4'h2, 0, 1};
        vecs[12] = '{"pos1 1",        4'hD, 7'h79,  8, 16'h6810, 4'hF, 4'h0, 0, 0};

        rst_n        = 1'b0;
        clear        = 1'b0;
        bus.dig_en_n = 4'hF;
        bus.seg_n    = 7'h7F;

        #12;
        checkOutput("reset digits", 32'(digits),     32'h0);
        checkOutput("reset valid",  32'(digitValid), 32'h0);
        checkOutput("reset blank",  32'(blank),      32'h0);
        checkOutput("reset frame",  32'(frameValid), 32'h0);
        checkOutput("reset err",    32'(err),        32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].digEn, vecs[i].seg, vecs[i].hold, e, f);
            checkOutput({vecs[i].name, " digits"}, 32'(digits),     32'(vecs[i].expDigits));
            checkOutput({vecs[i].name, " valid"},  32'(digitValid), 32'(vecs[i].expValid));
            checkOutput({vecs[i].name, " blank"},  32'(blank),      32'(vecs[i].expBlank));
            checkOutput({vecs[i].name, " errs"},   32'(e),          32'(vecs[i].expErr));
            checkOutput({vecs[i].name, " frames"}, 32'(f),          32'(vecs[i].expFrame));
            applyGap(vecs[i].name);
        end

        // Toggling 8 <-> 9 every 3 clocks never reaches the stability threshold
        et = 0;
        ft = 0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'hE, 7'h00, 3, e, f);
            et += e;
            ft += f;
            applyStimulus(4'hE, 7'h10, 3, e, f);
            et += e;
            ft += f;
        end
        checkOutput("toggle digits", 32'(digits), 32'h6810);
        checkOutput("toggle errs",   32'(et),     32'd0);
        checkOutput("toggle frames", 32'(ft),     32'd0);
        applyGap("toggle");

        // Reset in the middle of a dwell at count 5, then keep the same pattern
        applyStimulus(4'hB, 7'h10, 5, e, f);
        rst_n = 1'b0;
        #2;
        checkOutput("midreset digits", 32'(digits),     32'h0);
        checkOutput("midreset valid",  32'(digitValid), 32'h0);
        checkOutput("midreset blank",  32'(blank),      32'h0);
        checkOutput("midreset frame",  32'(frameValid), 32'h0);
        checkOutput("midreset err",    32'(err),        32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'hB, 7'h10, 7, e, f);
        checkOutput("postreset 7 valid",  32'(digitValid), 32'h0);
        checkOutput("postreset 7 digits", 32'(digits),     32'h0);
        applyStimulus(4'hB, 7'h10, 1, e, f);
        checkOutput("postreset 8 valid",  32'(digitValid), 32'h4);
        checkOutput("postreset 8 digits", 32'(digits),     32'h0900);
        applyGap("postreset");

        // clear on the accepting cycle wins: nothing written, valid stays 0
        applyStimulus(4'hE, 7'h79, 7, e, f);
        clear = 1'b1;
        applyStimulus(4'hE, 7'h79, 1, e, f);
        clear = 1'b0;
        checkOutput("clear+accept valid",  32'(digitValid), 32'h0);
        checkOutput("clear+accept blank",  32'(blank),      32'h0);
        checkOutput("clear+accept digits", 32'(digits),     32'h0900);
        applyStimulus(4'hE, 7'h79, 5, e, f);
        checkOutput("saturated valid",  32'(digitValid), 32'h0);
        checkOutput("saturated frames", 32'(f),          32'd0);
        applyGap("clear");
        applyStimulus(4'hE, 7'h79, 8, e, f);
        checkOutput("reaccept valid",  32'(digitValid), 32'h1);
        checkOutput("reaccept digits", 32'(digits),     32'h0901);
        applyGap("reaccept");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
